// File: rtl/cdc_bit_data_sync.sv
// rtl/cdc_bit_data_sync.sv - destination-side CDC synchronizer for independent bits and a coherent data word
// Bits pass a plain flop chain; the word is also held back until it has been seen unchanged long enough.
module cdc_bit_data_sync #(
    parameter int NUM_OF_BITS   = 1,
    parameter int DATA_WIDTH    = 16,
    parameter int ASYNC_CLK     = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                   out_clk,
    input  logic                   out_resetn,
    input  logic [NUM_OF_BITS-1:0] in_bits,
    output logic [NUM_OF_BITS-1:0] out_bits,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_data_update
);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
            $error("cdc_bit_data_sync: SYNC_STAGES must be in 2..4");
        end
        if (STABLE_CYCLES < 1 || STABLE_CYCLES > 15) begin : g_bad_stable
            $error("cdc_bit_data_sync: STABLE_CYCLES must be in 1..15");
        end
    endgenerate

    generate
        if (ASYNC_CLK != 0) begin : g_async
            localparam logic [3:0] STABLE_MAX  = 4'(STABLE_CYCLES);
            localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);

            logic [SYNC_STAGES-1:0][NUM_OF_BITS-1:0] bit_sync_q, bit_sync_d;
            logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0]  data_sync_q, data_sync_d;
            logic [DATA_WIDTH-1:0]                   sample_q, sample_d;
            logic [3:0]                              cnt_q, cnt_d;
            logic [DATA_WIDTH-1:0]                   out_data_q, out_data_d;
            logic                                    update_q, update_d;
            logic [DATA_WIDTH-1:0]                   data_last;
            logic                                    stable;
            logic                                    take_word;

            always_comb begin
                bit_sync_d  = {bit_sync_q[SYNC_STAGES-2:0], in_bits};
                data_sync_d = {data_sync_q[SYNC_STAGES-2:0], in_data};
                data_last   = data_sync_q[SYNC_STAGES-1];
                sample_d    = data_last;
                stable      = (data_last == sample_q);
                cnt_d       = cnt_q;
                if (!stable) begin
                    cnt_d = 4'd0;
                end else if (cnt_q < STABLE_MAX) begin
                    cnt_d = cnt_q + 4'd1;
                end
                // Counter saturates past STABLE_LAST, so a settled word qualifies exactly once.
                take_word  = stable && (cnt_q == STABLE_LAST) && (data_last != out_data_q);
                out_data_d = take_word ? data_last : out_data_q;
                update_d   = take_word;
            end

            always_ff @(posedge out_clk or negedge out_resetn) begin
                if (!out_resetn) begin
                    bit_sync_q  <= '0;
                    data_sync_q <= '0;
                    sample_q    <= '0;
                    cnt_q       <= '0;
                    out_data_q  <= '0;
                    update_q    <= 1'b0;
                end else begin
                    bit_sync_q  <= bit_sync_d;
                    data_sync_q <= data_sync_d;
                    sample_q    <= sample_d;
                    cnt_q       <= cnt_d;
                    out_data_q  <= out_data_d;
                    update_q    <= update_d;
                end
            end

            assign out_bits        = bit_sync_q[SYNC_STAGES-1];
            assign out_data        = out_data_q;
            assign out_data_update = update_q;
        end else begin : g_bypass
            assign out_bits        = in_bits;
            assign out_data        = in_data;
            assign out_data_update = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_cdc_bit_data_sync.sv
// tb/tb_cdc_bit_data_sync.sv - directed self-checking bench for cdc_bit_data_sync
module tb_cdc_bit_data_sync;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  in_bits;
    logic [1:0]  out_bits;
    logic [15:0] in_data;
    logic [15:0] out_data;
    logic        out_upd;

    logic [1:0]  byp_in_bits;
    logic [1:0]  byp_out_bits;
    logic [15:0] byp_in_data;
    logic [15:0] byp_out_data;
    logic        byp_upd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cdc_bit_data_sync #(
        .NUM_OF_BITS(2), .DATA_WIDTH(16), .ASYNC_CLK(1), .SYNC_STAGES(2), .STABLE_CYCLES(2)
    ) dut (
        .out_clk(clk), .out_resetn(rst_n),
        .in_bits(in_bits), .out_bits(out_bits),
        .in_data(in_data), .out_data(out_data), .out_data_update(out_upd)
    );

    cdc_bit_data_sync #(
        .NUM_OF_BITS(2), .DATA_WIDTH(16), .ASYNC_CLK(0), .SYNC_STAGES(2), .STABLE_CYCLES(2)
    ) dut_byp (
        .out_clk(clk), .out_resetn(rst_n),
        .in_bits(byp_in_bits), .out_bits(byp_out_bits),
        .in_data(byp_in_data), .out_data(byp_out_data), .out_data_update(byp_upd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        in_bits     = 2'b11;
        in_data     = 16'hFFFF;
        byp_in_bits = 2'b00;
        byp_in_data = 16'h0000;

        // Reset hold
        repeat (10) tick();
        check("rst_bits", 32'(out_bits), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_upd",  32'(out_upd),  32'h0);

        // Release: bits at edge 2, data pulse at edge 5
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("rel_bits_e%0d", e), 32'(out_bits), (e >= 2) ? 32'h3 : 32'h0);
            check($sformatf("rel_data_e%0d", e), 32'(out_data), (e >= 5) ? 32'hFFFF : 32'h0);
            check($sformatf("rel_upd_e%0d", e),  32'(out_upd),  (e == 5) ? 32'h1 : 32'h0);
        end

        // Bits latency
        in_bits = 2'b00;
        tick(); check("bits_fall_e1", 32'(out_bits), 32'h3);
        tick(); check("bits_fall_e2", 32'(out_bits), 32'h0);
        in_bits = 2'b10;
        tick(); check("bits_rise_e1", 32'(out_bits), 32'h0);
        tick(); check("bits_rise_e2", 32'(out_bits), 32'h2);

        // Data latency 0000 -> 1234
        in_data = 16'h0000;
        repeat (8) tick();
        check("settle_0000", 32'(out_data), 32'h0000);
        in_data = 16'h1234;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check($sformatf("lat_data_e%0d", e), 32'(out_data), (e >= 5) ? 32'h1234 : 32'h0000);
            check($sformatf("lat_upd_e%0d", e),  32'(out_upd),  (e == 5) ? 32'h1 : 32'h0);
        end

        // Glitch rejection; the last loop value (5555) starts the hold at its edge 1
        for (int i = 0; i < 20; i++) begin
            in_data = (i % 2 == 0) ? 16'hAAAA : 16'h5555;
            tick();
            check($sformatf("glitch_data_%0d", i), 32'(out_data), 32'h1234);
            check($sformatf("glitch_upd_%0d", i),  32'(out_upd),  32'h0);
        end
        for (int e = 2; e <= 9; e++) begin
            tick();
            check($sformatf("hold_data_e%0d", e), 32'(out_data), (e >= 5) ? 32'h5555 : 32'h1234);
            check($sformatf("hold_upd_e%0d", e),  32'(out_upd),  (e == 5) ? 32'h1 : 32'h0);
        end

        // Async reset between edges 3 and 4 of a pending update
        in_data = 16'h0F0F;
        repeat (3) tick();
        check("pre_rst_data", 32'(out_data), 32'h5555);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_bits", 32'(out_bits), 32'h0);
        check("async_rst_data", 32'(out_data), 32'h0);
        check("async_rst_upd",  32'(out_upd),  32'h0);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("rerel_bits_e%0d", e), 32'(out_bits), (e >= 2) ? 32'h2 : 32'h0);
            check($sformatf("rerel_data_e%0d", e), 32'(out_data), (e >= 5) ? 32'h0F0F : 32'h0);
            check($sformatf("rerel_upd_e%0d", e),  32'(out_upd),  (e == 5) ? 32'h1 : 32'h0);
        end

        // Bypass instance follows combinationally
        byp_in_bits = 2'b01;
        byp_in_data = 16'hBEEF;
        #1;
        check("byp_bits_a", 32'(byp_out_bits), 32'h1);
        check("byp_data_a", 32'(byp_out_data), 32'hBEEF);
        check("byp_upd_a",  32'(byp_upd),      32'h0);
        byp_in_bits = 2'b10;
        byp_in_data = 16'h1357;
        #1;
        check("byp_bits_b", 32'(byp_out_bits), 32'h2);
        check("byp_data_b", 32'(byp_out_data), 32'h1357);
        tick();
        check("byp_upd_b",  32'(byp_upd),      32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
